// File: rtl/pulp_cluster_package.sv
// Shared cluster constants and helpers for the peripheral plug combiners.
package pulp_cluster_package;

  // Default depth of the response-routing FIFO in a plug combiner.
  localparam int SPERIPH_MAX_OUTSTANDING = 2;

  // Number of slave plugs merged in front of the event unit.
  localparam int NB_SPERIPH_PLUGS_EU = 2;

  // Width of a plug index; a single plug still needs a 1-bit index.
  function automatic int speriph_idx_width(input int nb_plugs);
    return (nb_plugs > 1) ? $clog2(nb_plugs) : 1;
  endfunction

endpackage

// File: rtl/cluster_speriph_route_fifo.sv
// Response-routing FIFO: remembers which plug issued each in-flight request.
module cluster_speriph_route_fifo #(
  parameter int DEPTH      = 2,
  parameter int DATA_WIDTH = 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          push_i,
  input  logic [DATA_WIDTH-1:0]         data_i,
  input  logic                          pop_i,
  output logic [DATA_WIDTH-1:0]         data_o,
  output logic                          empty_o,
  output logic                          full_o,
  output logic [$clog2(DEPTH+1)-1:0]    count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_q;
  logic [PTR_W-1:0]                 wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]                 count_q;
  logic                             push_ok, pop_ok;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Pointer and occupancy tracking; simultaneous push/pop leaves count unchanged.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (pop_ok)  rd_ptr_q <= next_ptr(rd_ptr_q);
      count_q <= count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  // Storage needs no reset: entries are only read once counted valid.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/cluster_speriph_plug_arb.sv
// Round-robin combiner of NB_PLUGS peripheral slave plugs onto one target,
// with in-order response routing back to the issuing plug.
module cluster_speriph_plug_arb
  import pulp_cluster_package::*;
#(
  parameter int NB_PLUGS        = 2,
  parameter int ID_WIDTH        = 5,
  parameter int MAX_OUTSTANDING = SPERIPH_MAX_OUTSTANDING
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [NB_PLUGS-1:0]                plug_req_i,
  input  logic [NB_PLUGS-1:0][31:0]          plug_add_i,
  input  logic [NB_PLUGS-1:0]                plug_wen_i,
  input  logic [NB_PLUGS-1:0][31:0]          plug_wdata_i,
  input  logic [NB_PLUGS-1:0][3:0]           plug_be_i,
  input  logic [NB_PLUGS-1:0][ID_WIDTH-1:0]  plug_id_i,
  output logic [NB_PLUGS-1:0]                plug_gnt_o,
  output logic [NB_PLUGS-1:0]                plug_r_valid_o,
  output logic                               plug_r_opc_o,
  output logic [ID_WIDTH-1:0]                plug_r_id_o,
  output logic [31:0]                        plug_r_rdata_o,
  output logic                               tgt_req_o,
  output logic [31:0]                        tgt_add_o,
  output logic                               tgt_wen_o,
  output logic [31:0]                        tgt_wdata_o,
  output logic [3:0]                         tgt_be_o,
  output logic [ID_WIDTH-1:0]                tgt_id_o,
  input  logic                               tgt_gnt_i,
  input  logic                               tgt_r_valid_i,
  input  logic                               tgt_r_opc_i,
  input  logic [ID_WIDTH-1:0]                tgt_r_id_i,
  input  logic [31:0]                        tgt_r_rdata_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
  output logic                               err_o
);

  localparam int               IDX_W    = speriph_idx_width(NB_PLUGS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB_PLUGS-1);

  logic [IDX_W-1:0] rr_ptr_q, arb_idx, sel_idx, lock_idx_q, head_idx;
  logic             lock_q, req_valid, fifo_full, fifo_empty;
  logic             handshake, pop, err_q;

  // Round-robin search starting at the plug after the last granted one.
  always_comb begin : arb_comb
    int               cand;
    logic [IDX_W-1:0] cand_idx;
    logic             found;
    arb_idx  = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int i = 0; i < NB_PLUGS; i++) begin
      cand = int'(rr_ptr_q) + 1 + i;
      if (cand >= NB_PLUGS) cand = cand - NB_PLUGS;
      cand_idx = IDX_W'(cand);
      if (!found && plug_req_i[cand_idx]) begin
        found   = 1'b1;
        arb_idx = cand_idx;
      end
    end
  end

  // A stalled request keeps its plug so the target sees stable fields.
  assign sel_idx   = lock_q ? lock_idx_q : arb_idx;
  // arb_idx only points at an idle plug when nobody requests at all.
  assign req_valid = plug_req_i[sel_idx];
  // Full blocks on occupancy alone: a same-cycle pop never frees the slot.
  assign tgt_req_o = req_valid & ~fifo_full & ~rst_i;
  assign handshake = tgt_req_o & tgt_gnt_i;
  assign pop       = tgt_r_valid_i & ~fifo_empty & ~rst_i;

  assign tgt_add_o   = plug_add_i[sel_idx];
  assign tgt_wen_o   = plug_wen_i[sel_idx];
  assign tgt_wdata_o = plug_wdata_i[sel_idx];
  assign tgt_be_o    = plug_be_i[sel_idx];
  assign tgt_id_o    = plug_id_i[sel_idx];

  assign plug_r_opc_o   = tgt_r_opc_i;
  assign plug_r_id_o    = tgt_r_id_i;
  assign plug_r_rdata_o = tgt_r_rdata_i;
  assign err_o          = err_q;

  // One-hot grant and response-valid steering.
  always_comb begin
    plug_gnt_o     = '0;
    plug_r_valid_o = '0;
    if (handshake) plug_gnt_o[sel_idx]     = 1'b1;
    if (pop)       plug_r_valid_o[head_idx] = 1'b1;
  end

  // Pointer, lock and sticky orphan-response flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q   <= LAST_IDX;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (handshake && NB_PLUGS > 1) rr_ptr_q <= sel_idx;
      lock_q     <= tgt_req_o & ~tgt_gnt_i;
      lock_idx_q <= sel_idx;
      if (tgt_r_valid_i && fifo_empty) err_q <= 1'b1;
    end
  end

  cluster_speriph_route_fifo #(
    .DEPTH      (MAX_OUTSTANDING),
    .DATA_WIDTH (IDX_W)
  ) i_route_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (handshake),
    .data_i  (sel_idx),
    .pop_i   (pop),
    .data_o  (head_idx),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (outstanding_o)
  );

endmodule

// File: tb/tb_cluster_speriph_plug_arb.sv
// Directed bench for the two-plug combiner with a two-deep routing FIFO.
module tb_cluster_speriph_plug_arb;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       plug_req;
  logic [1:0][31:0] plug_add;
  logic [1:0]       plug_wen;
  logic [1:0][31:0] plug_wdata;
  logic [1:0][3:0]  plug_be;
  logic [1:0][4:0]  plug_id;
  logic [1:0]       plug_gnt, plug_r_valid;
  logic             plug_r_opc;
  logic [4:0]       plug_r_id;
  logic [31:0]      plug_r_rdata;
  logic             tgt_req, tgt_wen, tgt_gnt, tgt_r_valid, tgt_r_opc;
  logic [31:0]      tgt_add, tgt_wdata, tgt_r_rdata;
  logic [3:0]       tgt_be;
  logic [4:0]       tgt_id, tgt_r_id;
  logic [1:0]       outstanding;
  logic             err;

  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  cluster_speriph_plug_arb #(
    .NB_PLUGS(2), .ID_WIDTH(5), .MAX_OUTSTANDING(2)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .plug_req_i(plug_req), .plug_add_i(plug_add), .plug_wen_i(plug_wen),
    .plug_wdata_i(plug_wdata), .plug_be_i(plug_be), .plug_id_i(plug_id),
    .plug_gnt_o(plug_gnt), .plug_r_valid_o(plug_r_valid),
    .plug_r_opc_o(plug_r_opc), .plug_r_id_o(plug_r_id), .plug_r_rdata_o(plug_r_rdata),
    .tgt_req_o(tgt_req), .tgt_add_o(tgt_add), .tgt_wen_o(tgt_wen),
    .tgt_wdata_o(tgt_wdata), .tgt_be_o(tgt_be), .tgt_id_o(tgt_id),
    .tgt_gnt_i(tgt_gnt), .tgt_r_valid_i(tgt_r_valid), .tgt_r_opc_i(tgt_r_opc),
    .tgt_r_id_i(tgt_r_id), .tgt_r_rdata_i(tgt_r_rdata),
    .outstanding_o(outstanding), .err_o(err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    if (obs !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change here, checks at negedge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; plug_req = 2'b11; tgt_gnt = 1'b1; tgt_r_valid = 1'b1;
    plug_add = '0; plug_wen = 2'b01; plug_wdata = '0; plug_be = '1;
    plug_id = {5'h0B, 5'h03}; tgt_r_opc = 1'b0; tgt_r_id = '0; tgt_r_rdata = '0;

    // Reset cycle: outputs forced low even with requests/responses present.
    @(negedge clk);
    chk("rst_req", tgt_req, 0);
    chk("rst_gnt", plug_gnt, 2'b00);
    chk("rst_rvalid", plug_r_valid, 2'b00);
    tick();

    // Continuous requests, always granted: 0,1,0,1 with responses trailing.
    rst = 1'b0; tgt_r_valid = 1'b0;
    @(negedge clk);
    chk("init_outstanding", outstanding, 0);
    chk("init_err", err, 0);
    chk("rr_gnt0", plug_gnt, 2'b01);
    tick();
    tgt_r_valid = 1'b1; tgt_r_rdata = 32'h1;
    @(negedge clk);
    chk("rr_gnt1", plug_gnt, 2'b10);
    chk("rr_rv0", plug_r_valid, 2'b01);
    chk("rr_out1", outstanding, 1);
    tick();
    @(negedge clk);
    chk("rr_gnt2", plug_gnt, 2'b01);
    chk("rr_rv1", plug_r_valid, 2'b10);
    tick();
    @(negedge clk);
    chk("rr_gnt3", plug_gnt, 2'b10);
    chk("rr_rv2", plug_r_valid, 2'b01);
    chk("rr_out_pushpop", outstanding, 1);
    tick();
    plug_req = 2'b00;
    @(negedge clk);
    chk("rr_rv3", plug_r_valid, 2'b10);
    chk("rr_idle_req", tgt_req, 0);
    tick();

    // Stalled request from plug 1 must hold while plug 0 joins in.
    tgt_r_valid = 1'b0; tgt_gnt = 1'b0; plug_req = 2'b10;
    plug_add = {32'h10200040, 32'h10200000};
    @(negedge clk);
    chk("lock_req", tgt_req, 1);
    chk("lock_add0", tgt_add, 32'h10200040);
    chk("lock_nognt", plug_gnt, 2'b00);
    tick();
    plug_req = 2'b11;
    @(negedge clk);
    chk("lock_add1", tgt_add, 32'h10200040);
    tick();
    @(negedge clk);
    chk("lock_add2", tgt_add, 32'h10200040);
    tick();
    tgt_gnt = 1'b1;
    @(negedge clk);
    chk("lock_add3", tgt_add, 32'h10200040);
    chk("lock_gnt", plug_gnt, 2'b10);
    tick();
    plug_req = 2'b00; tgt_gnt = 1'b0; tgt_r_valid = 1'b1;
    @(negedge clk);
    chk("lock_rv", plug_r_valid, 2'b10);
    chk("lock_out", outstanding, 1);
    tick();

    // Fill the FIFO (plug 1 then plug 0), block, then drain in order.
    tgt_r_valid = 1'b0; plug_req = 2'b10; tgt_gnt = 1'b1;
    @(negedge clk);
    chk("ord_gnt1", plug_gnt, 2'b10);
    chk("ord_out0", outstanding, 0);
    tick();
    plug_req = 2'b01;
    @(negedge clk);
    chk("ord_gnt0", plug_gnt, 2'b01);
    chk("ord_out1", outstanding, 1);
    tick();
    plug_req = 2'b11; tgt_r_valid = 1'b1; tgt_r_rdata = 32'hAAAA0001; tgt_r_id = 5'h15;
    @(negedge clk);
    chk("full_out", outstanding, 2);
    chk("full_req", tgt_req, 0);
    chk("full_gnt", plug_gnt, 2'b00);
    chk("ord_rv_a", plug_r_valid, 2'b10);
    chk("ord_rdata_a", plug_r_rdata, 32'hAAAA0001);
    chk("ord_rid_a", plug_r_id, 5'h15);
    tick();
    tgt_gnt = 1'b0; tgt_r_rdata = 32'hBBBB0002;
    @(negedge clk);
    chk("unblock_req", tgt_req, 1);
    chk("unblock_out", outstanding, 1);
    chk("ord_rv_b", plug_r_valid, 2'b01);
    chk("ord_rdata_b", plug_r_rdata, 32'hBBBB0002);
    chk("unblock_id", tgt_id, 5'h0B);
    tick();

    // One request in flight, then reset discards it.
    plug_req = 2'b00; tgt_r_valid = 1'b0;
    tick();
    plug_req = 2'b01; tgt_gnt = 1'b1;
    @(negedge clk);
    chk("pre_rst_gnt", plug_gnt, 2'b01);
    tick();
    rst = 1'b1; plug_req = 2'b11; tgt_r_valid = 1'b1;
    @(negedge clk);
    chk("mid_rst_out", outstanding, 1);
    chk("mid_rst_gnt", plug_gnt, 2'b00);
    chk("mid_rst_rv", plug_r_valid, 2'b00);
    tick();
    rst = 1'b0; plug_req = 2'b00; tgt_gnt = 1'b0; tgt_r_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_out", outstanding, 0);
    chk("post_rst_gnt", plug_gnt, 2'b00);
    chk("post_rst_rv", plug_r_valid, 2'b00);
    chk("post_rst_err", err, 0);
    tick();

    // Orphan response sets a sticky error cleared only by reset.
    tgt_r_valid = 1'b1;
    @(negedge clk);
    chk("orphan_rv", plug_r_valid, 2'b00);
    chk("orphan_err_pre", err, 0);
    tick();
    tgt_r_valid = 1'b0;
    @(negedge clk);
    chk("err_set", err, 1);
    tick();
    @(negedge clk);
    chk("err_hold", err, 1);
    tick();
    plug_req = 2'b11; tgt_gnt = 1'b1;
    @(negedge clk);
    chk("rst_prio_gnt", plug_gnt, 2'b01);
    chk("err_hold2", err, 1);
    tick();
    rst = 1'b1; plug_req = 2'b00; tgt_gnt = 1'b0;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("err_clr", err, 0);
    chk("err_clr_out", outstanding, 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
